// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch constants, next-PC select encoding and ROM image.
package mips_pkg;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  typedef enum logic [2:0] {NPC_SEQ, NPC_BR, NPC_J, NPC_JR, NPC_ERET, NPC_EXC, NPC_PEND} npc_sel_e;
  // Boot image: word i holds "addiu $t0,$zero,i".
  function automatic logic [31:0] rom_init(int unsigned i);
    return {16'h2408, i[15:0]};
  endfunction
endpackage

// File: rtl/imem_rom.sv
// imem_rom: word-addressed instruction ROM with asynchronous read.
module imem_rom import mips_pkg::*; #(
  parameter int IMEM_AW = 12
) (
  input  logic [IMEM_AW-1:0] addr,
  output logic [31:0]        data
);
  logic [31:0] mem [2**IMEM_AW];
  for (genvar i = 0; i < 2**IMEM_AW; i++) begin : g_w
    assign mem[i] = rom_init(i);
  end
  assign data = mem[addr];
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS IF stage with next-PC select, stall-pending redirect and ROM fetch.
// Define FETCH_ADDR_CHECK_EN to flag misaligned/out-of-range fetches on exc_fetch.
module if_fetch_stage import mips_pkg::*; #(
  parameter logic [31:0] PC_RESET   = mips_pkg::PC_RESET,
  parameter logic [31:0] EXC_VECTOR = mips_pkg::EXC_VECTOR,
  parameter int          IMEM_AW    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic [31:0] pc8_out,
  output logic [31:0] Instr_out,
  output logic        redirect_pend,
  output logic        exc_fetch
);
  logic [31:0] pc_q, pc_d, pend_tgt_q, pend_tgt_d, redir_tgt, npc, off, rom_data;
  logic        pend_v_q, pend_v_d, redir, load, oor, unused_off;
  npc_sel_e    sel;
  assign pc_out = pc_q;
  assign pc4_out = pc_q + 32'd4;
  assign pc8_out = pc_q + 32'd8;
  assign redirect_pend = pend_v_q;
  always_comb begin
    redir = eret_req | jr | jmp | br_taken;
    redir_tgt = eret_req ? epc : jr ? jr_target : jmp ? jmp_target : br_target;
    sel = exc_req ? NPC_EXC : eret_req ? NPC_ERET : jr ? NPC_JR : jmp ? NPC_J :
          br_taken ? NPC_BR : pend_v_q ? NPC_PEND : NPC_SEQ;
    npc = sel == NPC_EXC ? EXC_VECTOR : sel == NPC_PEND ? pend_tgt_q :
          sel == NPC_SEQ ? pc4_out : redir_tgt;
    load = en | exc_req;
    pc_d = load ? npc : pc_q;
    pend_v_d = !load && (redir || pend_v_q);
    pend_tgt_d = (!load && redir) ? redir_tgt : pend_tgt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q <= PC_RESET;
      pend_v_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pc_q <= pc_d;
      pend_v_q <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
    end
  // Byte offset into the ROM; anything below the base or past the last word fetches a NOP.
  assign off = pc_q - PC_RESET;
  assign oor = (pc_q < PC_RESET) || ((off >> (IMEM_AW + 2)) != '0);
  assign unused_off = ^off[1:0];
  imem_rom #(.IMEM_AW(IMEM_AW)) u_rom (
    .addr(off[IMEM_AW+1:2]),
    .data(rom_data)
  );
`ifdef FETCH_ADDR_CHECK_EN
  assign exc_fetch = oor || (pc_q[1:0] != 2'b00);
  assign Instr_out = exc_fetch ? '0 : rom_data;
`else
  assign exc_fetch = 1'b0;
  assign Instr_out = oor ? '0 : rom_data;
`endif
endmodule
